// File: rtl/pc8001_rom_loader_pkg.sv
// Shared types and default region sizes for the PC-8001 ROM download path.
package pc8001_pkg;
  typedef enum logic [1:0] {ROM_MAIN, ROM_EXT, ROM_CG} rom_sel_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_SHORT, ERR_OVERRUN, ERR_GAP} load_err_t;
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_DONE, ST_ERROR} load_state_t;

  localparam int MAIN_SIZE_DEF = 24576;
  localparam int EXT_SIZE_DEF  = 8192;
  localparam int CG_SIZE_DEF   = 2048;
endpackage

// File: rtl/pc8001_rom_loader_if.sv
// ioctl download stream in, ROM write port and load status out.
interface pc8001_rom_loader_if;
  import pc8001_pkg::*;

  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        rom_wr;
  rom_sel_t    rom_sel;
  logic [14:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_ack;
  logic        core_reset;
  logic        load_done;
  load_err_t   load_error;
  logic [15:0] checksum;

  modport master (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, rom_ack,
    output ioctl_wait, rom_wr, rom_sel, rom_addr, rom_data,
           core_reset, load_done, load_error, checksum
  );

  modport slave (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, rom_ack,
    input  ioctl_wait, rom_wr, rom_sel, rom_addr, rom_data,
           core_reset, load_done, load_error, checksum
  );
endinterface

// File: rtl/pc8001_rom_region_decode.sv
// Maps an image byte offset to {region, offset within region}.
module pc8001_rom_region_decode
  import pc8001_pkg::*;
#(
  parameter int MAIN_SIZE = MAIN_SIZE_DEF,
  parameter int EXT_SIZE  = EXT_SIZE_DEF,
  parameter int CG_SIZE   = CG_SIZE_DEF
) (
  input  logic [24:0] off,
  output rom_sel_t    sel,
  output logic [14:0] addr,
  output logic        in_range
);
  localparam logic [24:0] EXT_BASE = 25'(MAIN_SIZE);
  localparam logic [24:0] CG_BASE  = 25'(MAIN_SIZE + EXT_SIZE);
  localparam logic [24:0] END_OFF  = 25'(MAIN_SIZE + EXT_SIZE + CG_SIZE);

  always_comb begin
    sel      = ROM_MAIN;
    addr     = 15'(off);
    in_range = 1'b1;
    if (off >= END_OFF) begin
      addr     = '0;
      in_range = 1'b0;
    end else if (off >= CG_BASE) begin
      sel  = ROM_CG;
      addr = 15'(off - CG_BASE);
    end else if (off >= EXT_BASE) begin
      sel  = ROM_EXT;
      addr = 15'(off - EXT_BASE);
    end
  end
endmodule

// File: rtl/pc8001_rom_loader.sv
// Turns the hps_io BIND88 download into ROM write cycles with a one-entry
// buffer, keeping the core in reset until a clean image has landed.
module pc8001_rom_loader
  import pc8001_pkg::*;
#(
  parameter logic [7:0] FILE_INDEX = 8'd1,
  parameter int         MAIN_SIZE  = MAIN_SIZE_DEF,
  parameter int         EXT_SIZE   = EXT_SIZE_DEF,
  parameter int         CG_SIZE    = CG_SIZE_DEF
) (
  input logic               clk_sys,
  input logic               reset,
  pc8001_rom_loader_if.master bus
);
  localparam logic [15:0] TOTAL_OFF = 16'(MAIN_SIZE + EXT_SIZE + CG_SIZE);

  load_state_t state;
  logic        buf_full;
  rom_sel_t    wr_sel;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic [15:0] exp_off;
  logic [15:0] csum;
  logic        done;
  load_err_t   err;
  logic        core_rst;

  rom_sel_t    dec_sel;
  logic [14:0] dec_addr;
  logic        dec_in_range;

  pc8001_rom_region_decode #(
    .MAIN_SIZE(MAIN_SIZE), .EXT_SIZE(EXT_SIZE), .CG_SIZE(CG_SIZE)
  ) u_decode (
    .off(bus.ioctl_addr), .sel(dec_sel), .addr(dec_addr), .in_range(dec_in_range)
  );

  logic start, short_img;
  assign start     = bus.ioctl_download && (bus.ioctl_index == FILE_INDEX);
  assign short_img = exp_off < TOTAL_OFF;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= ST_IDLE;
      buf_full <= 1'b0;
      wr_sel   <= ROM_MAIN;
      wr_addr  <= '0;
      wr_data  <= '0;
      exp_off  <= '0;
      csum     <= '0;
      done     <= 1'b0;
      err      <= ERR_NONE;
      core_rst <= 1'b1;
    end else if (start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR)) begin
      state    <= ST_LOAD;
      buf_full <= 1'b0;
      exp_off  <= '0;
      csum     <= '0;
      done     <= 1'b0;
      err      <= ERR_NONE;
      core_rst <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: core_rst <= 1'b0;
        ST_LOAD: begin
          if (buf_full && bus.rom_ack) buf_full <= 1'b0;
          if (!bus.ioctl_download) begin
            // A byte still waiting for the core must land before judging the image.
            if (buf_full) state <= ST_DRAIN;
            else if (short_img) begin
              err   <= ERR_SHORT;
              state <= ST_ERROR;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end else if (bus.ioctl_wr) begin
            // ioctl_wait was high, so a strobe now is an overrun even alongside rom_ack.
            if (buf_full) begin
              err      <= ERR_OVERRUN;
              buf_full <= 1'b0;
              state    <= ST_ERROR;
            end else if (dec_in_range) begin
              if (bus.ioctl_addr[15:0] != exp_off) begin
                err   <= ERR_GAP;
                state <= ST_ERROR;
              end else begin
                buf_full <= 1'b1;
                wr_sel   <= dec_sel;
                wr_addr  <= dec_addr;
                wr_data  <= bus.ioctl_dout;
                csum     <= csum + {8'h00, bus.ioctl_dout};
                exp_off  <= exp_off + 16'd1;
              end
            end
          end
        end
        ST_DRAIN: begin
          if (!buf_full || bus.rom_ack) begin
            buf_full <= 1'b0;
            if (short_img) begin
              err   <= ERR_SHORT;
              state <= ST_ERROR;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: core_rst <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.ioctl_wait = buf_full;
  assign bus.rom_wr     = buf_full;
  assign bus.rom_sel    = wr_sel;
  assign bus.rom_addr   = wr_addr;
  assign bus.rom_data   = wr_data;
  assign bus.core_reset = core_rst;
  assign bus.load_done  = done;
  assign bus.load_error = err;
  assign bus.checksum   = csum;
endmodule

// File: tb/tb_pc8001_rom_loader.sv
// Scoreboard bench: the ioctl driver queues expected ROM writes, a negedge
// monitor pops and compares each new rom_wr, an ack responder models the core.
module tb_pc8001_rom_loader;
  import pc8001_pkg::*;

  localparam int TOTAL = MAIN_SIZE_DEF + EXT_SIZE_DEF + CG_SIZE_DEF;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  pc8001_rom_loader_if bus();
  pc8001_rom_loader dut (.clk_sys(clk_sys), .reset(reset), .bus(bus));

  int          n_chk = 0;
  int          n_pass = 0;
  logic [24:0] exp_q[$];
  int          ack_dly = 0;
  bit          ack_en = 1'b1;
  int          wr_cnt[3];
  int          last_sel, last_addr, mon_sel;
  bit          seen = 1'b0;
  int          last_wait = 0;
  logic [15:0] ref_sum = '0;
  logic [24:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] pat(input int a);
    return 8'((a * 7) ^ (a >> 8));
  endfunction

  function automatic logic [24:0] exp_wr(input int a, input logic [7:0] d);
    if (a < MAIN_SIZE_DEF) return {2'd0, 15'(a), d};
    if (a < MAIN_SIZE_DEF + EXT_SIZE_DEF) return {2'd1, 15'(a - MAIN_SIZE_DEF), d};
    return {2'd2, 15'(a - MAIN_SIZE_DEF - EXT_SIZE_DEF), d};
  endfunction

  // Monitor: one comparison per ROM write, on its first cycle.
  always @(negedge clk_sys) begin
    if (bus.rom_wr && !seen) begin
      seen = 1'b1;
      mon_sel = int'(bus.rom_sel);
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected rom_wr: sel %0d addr %0h data %0h, no write expected",
                 mon_sel, bus.rom_addr, bus.rom_data);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("rom write {sel,addr,data}", {7'd0, bus.rom_sel, bus.rom_addr, bus.rom_data}, {7'd0, mon_exp});
      end
      if (mon_sel < 3) wr_cnt[mon_sel]++;
      last_sel  = mon_sel;
      last_addr = int'(bus.rom_addr);
    end else if (!bus.rom_wr) begin
      seen = 1'b0;
    end
  end

  // Core model: ack ack_dly cycles after a write first appears.
  initial begin
    bus.rom_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (bus.rom_wr && ack_en) begin
        repeat (ack_dly) @(negedge clk_sys);
        bus.rom_ack = 1'b1;
        @(negedge clk_sys);
        bus.rom_ack = 1'b0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic send_byte(input int a, input logic [7:0] d, input bit expect_wr);
    int w = 0;
    while (bus.ioctl_wait && w < 200) begin
      @(negedge clk_sys);
      w++;
    end
    last_wait = w;
    if (bus.ioctl_wait) begin
      n_chk++;
      $display("FAIL ioctl_wait timeout at offset %0h: still high after %0d cycles, expected low", a, w);
    end
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = 25'(a);
    bus.ioctl_dout = d;
    if (expect_wr) begin
      exp_q.push_back(exp_wr(a, d));
      ref_sum = ref_sum + {8'h00, d};
    end
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = idx;
    @(negedge clk_sys);
  endtask

  task automatic end_dl();
    bus.ioctl_download = 1'b0;
    @(negedge clk_sys);
  endtask

  initial begin
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    for (int i = 0; i < 3; i++) wr_cnt[i] = 0;

    // Reset values
    repeat (3) @(negedge clk_sys);
    chk("reset core_reset", bus.core_reset, 1);
    chk("reset rom_wr", bus.rom_wr, 0);
    chk("reset ioctl_wait", bus.ioctl_wait, 0);
    chk("reset load_done", bus.load_done, 0);
    chk("reset load_error", bus.load_error, 0);
    chk("reset checksum", bus.checksum, 0);
    reset = 1'b0;
    @(negedge clk_sys);
    chk("core_reset released after reset", bus.core_reset, 0);

    // Non-matching index is ignored
    start_dl(8'd0);
    for (int a = 0; a < 4; a++) send_byte(a, pat(a), 1'b0);
    end_dl();
    repeat (2) @(negedge clk_sys);
    chk("idx0 load_done", bus.load_done, 0);
    chk("idx0 load_error", bus.load_error, 0);
    chk("idx0 core_reset", bus.core_reset, 0);
    chk("idx0 checksum", bus.checksum, 0);

    // Short image, ack 2 cycles late, download ends with the buffer full
    ack_dly = 2;
    ref_sum = '0;
    start_dl(8'd1);
    chk("load entry core_reset", bus.core_reset, 1);
    for (int a = 0; a < 64; a++) send_byte(a, pat(a), 1'b1);
    end_dl();
    repeat (6) @(negedge clk_sys);
    chk("short load_error", bus.load_error, 1);
    chk("short load_done", bus.load_done, 0);
    chk("short core_reset", bus.core_reset, 1);
    chk("short checksum", bus.checksum, ref_sum);
    chk("short rom_wr", bus.rom_wr, 0);
    chk("short drained writes", exp_q.size(), 0);

    // Slow core: ioctl_wait spans latch to ack, then a forced overrun
    ack_dly = 10;
    start_dl(8'd1);
    send_byte(0, 8'h11, 1'b1);
    send_byte(1, 8'h22, 1'b1);
    chk("wait cycles byte1", last_wait, 11);
    send_byte(2, 8'h33, 1'b1);
    chk("wait cycles byte2", last_wait, 11);
    chk("ioctl_wait while full", bus.ioctl_wait, 1);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = 25'd3;
    bus.ioctl_dout = 8'h44;
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0;
    chk("overrun load_error", bus.load_error, 2);
    chk("overrun rom_wr", bus.rom_wr, 0);
    chk("overrun ioctl_wait", bus.ioctl_wait, 0);
    chk("overrun core_reset", bus.core_reset, 1);
    end_dl();
    repeat (15) @(negedge clk_sys);
    chk("overrun sticky", bus.load_error, 2);
    chk("overrun writes seen", exp_q.size(), 0);

    // Offset 0x10 skipped
    ack_dly = 0;
    start_dl(8'd1);
    for (int a = 0; a < 16; a++) send_byte(a, pat(a), 1'b1);
    send_byte(16'h11, 8'h5A, 1'b0);
    chk("gap load_error", bus.load_error, 3);
    chk("gap rom_wr", bus.rom_wr, 0);
    chk("gap core_reset", bus.core_reset, 1);
    end_dl();
    repeat (3) @(negedge clk_sys);

    // Full image plus a 256-byte tail beyond the CG region
    for (int i = 0; i < 3; i++) wr_cnt[i] = 0;
    ref_sum = '0;
    start_dl(8'd1);
    chk("full entry clears load_error", bus.load_error, 0);
    chk("full entry checksum", bus.checksum, 0);
    for (int a = 0; a < 16'h8900; a++) send_byte(a, pat(a), a < TOTAL);
    end_dl();
    chk("full load_done", bus.load_done, 1);
    chk("full core_reset at done", bus.core_reset, 1);
    @(negedge clk_sys);
    chk("full core_reset one cycle after done", bus.core_reset, 0);
    chk("full load_error", bus.load_error, 0);
    chk("full checksum", bus.checksum, ref_sum);
    chk("main write count", wr_cnt[0], 24576);
    chk("ext write count", wr_cnt[1], 8192);
    chk("cg write count", wr_cnt[2], 2048);
    chk("last write sel", last_sel, 2);
    chk("last write addr", last_addr, 32'h7FF);
    chk("full writes seen", exp_q.size(), 0);

    // Non-matching index after DONE leaves status alone
    start_dl(8'd0);
    send_byte(0, 8'hFF, 1'b0);
    send_byte(1, 8'hFE, 1'b0);
    end_dl();
    repeat (2) @(negedge clk_sys);
    chk("idx0 after done load_done", bus.load_done, 1);
    chk("idx0 after done checksum", bus.checksum, ref_sum);
    chk("idx0 after done core_reset", bus.core_reset, 0);

    // Reset with a write outstanding
    ack_en = 1'b0;
    start_dl(8'd1);
    send_byte(0, 8'hA5, 1'b1);
    chk("pending rom_wr", bus.rom_wr, 1);
    reset = 1'b1;
    @(negedge clk_sys);
    chk("mid reset rom_wr", bus.rom_wr, 0);
    chk("mid reset ioctl_wait", bus.ioctl_wait, 0);
    chk("mid reset core_reset", bus.core_reset, 1);
    chk("mid reset load_done", bus.load_done, 0);
    chk("mid reset load_error", bus.load_error, 0);
    chk("mid reset checksum", bus.checksum, 0);
    chk("mid reset rom bus", {7'd0, bus.rom_sel, bus.rom_addr, bus.rom_data}, 0);
    bus.ioctl_download = 1'b0;
    reset = 1'b0;
    ack_en = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("after reset rom_wr", bus.rom_wr, 0);
    chk("after reset core_reset", bus.core_reset, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pc8001_rom_loader.md
Name: pc8001_rom_loader

Overview:
- Upstream of the pc8001m core: converts the hps_io ioctl download stream for the OSD "Load ROM" (BIND88) file into write cycles on the core's ROM write port.
- Splits one image into three regions: main N-BASIC ROM, expansion ROM and character generator ROM.
- Applies backpressure through ioctl_wait, holds the core in reset while a load is in progress, and reports completion, checksum and error status.

Parameters:
- FILE_INDEX, 8'd1: ioctl_index value that selects this file; downloads with any other index are ignored.
- MAIN_SIZE, 24576: bytes in the main ROM region, image offsets 0x0000-0x5FFF.
- EXT_SIZE, 8192: bytes in the expansion ROM region, following the main region.
- CG_SIZE, 2048: bytes in the CGROM region, following the expansion region.

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  download active.
- ioctl_index  in  8  file index.
- ioctl_wr  in  1  one-cycle strobe: ioctl_dout is valid at ioctl_addr.
- ioctl_addr  in  25  byte offset within the image.
- ioctl_dout  in  8  data byte.
- ioctl_wait  out  1  stall request to hps_io.
- rom_wr  out  1  write request to the core; held until acknowledged.
- rom_sel  out  2  target region: 0 = main, 1 = ext, 2 = CG.
- rom_addr  out  15  offset within the selected region.
- rom_data  out  8  write data.
- rom_ack  in  1  one-cycle acknowledge from the core.
- core_reset  out  1  holds the pc8001m core in reset.
- load_done  out  1  sticky: last load completed without error.
- load_error  out  2  sticky: 0 = ok, 1 = short image, 2 = overrun, 3 = address gap.
- checksum  out  16  modulo-2^16 sum of all accepted bytes.

Behaviour:
- Reset values:
  - All outputs 0, except core_reset = 1.
  - State IDLE, buffer empty, expected offset 0.
  - Reset mid-load abandons the load; no further rom_wr is issued.
- States: IDLE, LOAD, DRAIN, DONE, ERROR.
- IDLE:
  - Entered after reset. core_reset is released one cycle after reset deasserts.
  - Moves to LOAD when ioctl_download = 1 and ioctl_index == FILE_INDEX.
  - On entry to LOAD: core_reset = 1; load_done, load_error, checksum and expected offset are cleared.
- LOAD:
  - Each ioctl_wr with the buffer empty is latched into the one-entry buffer. checksum += byte; expected offset += 1.
  - Decode, with off = ioctl_addr:
    - off < MAIN_SIZE: sel 0, addr = off.
    - off < MAIN_SIZE + EXT_SIZE: sel 1, addr = off - MAIN_SIZE.
    - off < TOTAL: sel 2, addr = off - MAIN_SIZE - EXT_SIZE.
    - off >= TOTAL: byte is discarded and counted in neither checksum nor offset. Not an error.
  - ioctl_addr != expected offset (when < TOTAL): load_error = 3, go to ERROR.
- Buffer and handshake:
  - rom_wr is asserted the cycle after the buffer is latched.
  - rom_sel, rom_addr and rom_data stay stable while rom_wr = 1.
  - rom_ack with rom_wr = 1 empties the buffer and drops rom_wr on the next cycle.
  - rom_ack without rom_wr is ignored.
  - ioctl_wait = buffer full; it is combinational from the buffer flag, with no extra latency.
  - ioctl_wr while the buffer is full: byte dropped, load_error = 2, go to ERROR.
  - ioctl_wr in the same cycle as rom_ack (buffer full) is still an overrun, because ioctl_wait was high.
- Download end (ioctl_download falls):
  - Buffer full: go to DRAIN, and wait for rom_ack.
  - Buffer empty: evaluate immediately.
  - Evaluation: expected offset < TOTAL gives load_error = 1 and ERROR; otherwise DONE.
- DONE: load_done = 1; core_reset is deasserted the following cycle.
- ERROR:
  - rom_wr is forced low, the pending buffer is discarded, ioctl_wait = 0.
  - core_reset stays 1 until the next successful load or reset.
- From DONE or ERROR, a new matching download re-enters LOAD. Non-matching indices never affect any state.
- Width rules: internal offset counter is 16 bits (TOTAL <= 65535); ioctl_addr bits 24:16 nonzero count as off >= TOTAL.

Decomposition:
- Shared package pc8001_pkg holds:
  - rom_sel_t enum (ROM_MAIN, ROM_EXT, ROM_CG).
  - load_err_t enum (ERR_NONE, ERR_SHORT, ERR_OVERRUN, ERR_GAP).
  - Loader state enum.
  - Default region size constants.
- One sub-module, pc8001_rom_region_decode: combinational offset-to-{sel, addr, in_range} mapping, parameterised by the three sizes.

Test Plan:
- Full 34816-byte image, rom_ack returned 2 cycles after each rom_wr:
  - Expect 24576 writes with sel 0, 8192 with sel 1 and 2048 with sel 2.
  - The last write is sel 2, addr 0x7FF.
  - load_done = 1 and checksum equals the reference sum.
  - core_reset falls exactly 1 cycle after DONE.
- rom_ack delayed 10 cycles:
  - ioctl_wait is high from buffer latch until ack; no bytes lost.
  - An extra ioctl_wr forced while ioctl_wait = 1 gives load_error = 2 and rom_wr = 0 the next cycle.
- 20000-byte image: load_error = 1, load_done = 0, core_reset stays 1.
- Image of 0x8900 bytes: bytes 0x8800-0x88FF generate no rom_wr, and the load ends in DONE.
- Offset 0x0010 skipped (0x0F followed by 0x11): load_error = 3.
- Other cases:
  - ioctl_index = 0 download is ignored (no rom_wr, status unchanged).
  - reset asserted mid-load with rom_wr high: all outputs return to their reset values the next cycle.
